// File: rtl/ldl_p2ram_rd_arb.sv
// Round-robin arbiter sharing one registered-read RAM port among NR clients.
// Tracks the in-flight read per client, routes responses back, and replays collided reads.
module ldl_p2ram_rd_arb #(
  parameter int NR    = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 10,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR-1:0]    req,
  input  logic [NR*AW-1:0] addr,
  output logic [NR-1:0]    gnt,
  output logic [NR-1:0]    rvld,
  output logic [DW-1:0]    rdata,
  output logic             ram_re,
  output logic [AW-1:0]    ram_ra,
  input  logic [DW-1:0]    ram_dout,
  input  logic             ram_rv,
  output logic [CW-1:0]    retry_cnt
);

  localparam int PW = $clog2(NR);

  logic [PW-1:0] ptr;
  logic [NR-1:0] infl;
  logic [NR-1:0] tag;
  logic [NR-1:0] eligible;
  logic [PW-1:0] gidx;
  logic          found;
  int            sel;

  // Gating with rst keeps the RAM port quiet while reset is held.
  assign eligible = req & ~infl & {NR{~rst}};

  always_comb begin
    gnt    = '0;
    gidx   = ptr;
    found  = 1'b0;
    ram_ra = '0;
    sel    = 0;
    for (int k = 1; k <= NR; k++) begin
      sel = int'(ptr) + k;
      if (sel >= NR) sel = sel - NR;
      for (int i = 0; i < NR; i++) begin
        if (!found && eligible[i] && (sel == i)) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          gidx   = PW'(i);
          ram_ra = addr[i*AW +: AW];
        end
      end
    end
  end

  assign ram_re = found;
  assign rvld   = tag & {NR{ram_rv}};
  assign rdata  = ram_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= PW'(NR - 1);
      infl      <= '0;
      tag       <= '0;
      retry_cnt <= '0;
    end else begin
      // The responding client always leaves flight; a collided read re-arbitrates via its held req.
      infl <= (infl & ~tag) | gnt;
      tag  <= gnt;
      if (found) ptr <= gidx;
      if ((tag != '0) && !ram_rv && (retry_cnt != {CW{1'b1}}))
        retry_cnt <= retry_cnt + 1'b1;
    end
  end

endmodule
